// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer slave: register offsets, bit indices, bus FSM states.
// Optional TSR/IER/irq support is enabled with APB_TIMER_IRQ_EN.
package apb_timer_pkg;

    localparam logic [2:0] OFF_TCR  = 3'd0;
    localparam logic [2:0] OFF_TCNT = 3'd1;
    localparam logic [2:0] OFF_PSC  = 3'd2;
    localparam logic [2:0] OFF_ARR  = 3'd3;
    localparam logic [2:0] OFF_TSR  = 3'd4;
    localparam logic [2:0] OFF_IER  = 3'd5;

    localparam int TCR_EN  = 0;
    localparam int TCR_CLR = 1;
    localparam int TSR_UIF = 0;
    localparam int IER_UIE = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } bus_state_e;

endpackage

// File: rtl/apb_timer_slave_timer_core.sv
// Prescaler, up-counter and update flag of the APB timer.
// The update flag exists only when APB_TIMER_IRQ_EN is defined.
module timer_core
    import apb_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] psc,
    input  logic [CNT_W-1:0] arr,
    input  logic             uif_clr,
    output logic [CNT_W-1:0] tcnt,
    output logic             uif
);

    logic [CNT_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             tick;
    logic             wrap;

    always_comb begin
        psc_cnt_d = psc_cnt_q;
        tcnt_d    = tcnt_q;
        tick      = 1'b0;
        wrap      = 1'b0;
        if (clr) begin
            psc_cnt_d = '0;
            tcnt_d    = '0;
        end else if (en) begin
            // >= keeps the prescaler from running away if PSC is lowered mid-count
            if (psc_cnt_q >= psc) begin
                psc_cnt_d = '0;
                tick      = 1'b1;
            end else begin
                psc_cnt_d = psc_cnt_q + CNT_W'(1);
            end
            if (tick) begin
                if (tcnt_q >= arr) begin
                    tcnt_d = '0;
                    wrap   = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt_q <= '0;
            tcnt_q    <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
            tcnt_q    <= tcnt_d;
        end
    end

    assign tcnt = tcnt_q;

`ifdef APB_TIMER_IRQ_EN
    logic uif_q, uif_d;

    // a wrap in the same cycle as a W1C keeps the flag set
    always_comb begin
        uif_d = wrap | (uif_q & ~uif_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uif_q <= 1'b0;
        end else begin
            uif_q <= uif_d;
        end
    end

    assign uif = uif_q;
`else
    logic unused_uif;
    assign unused_uif = wrap ^ uif_clr;
    assign uif        = 1'b0;
`endif

endmodule

// File: rtl/apb_timer_slave.sv
// APB completer wrapping a prescaled up-counter timer with wait-state insertion.
// Define APB_TIMER_IRQ_EN to implement TSR/IER and the irq output.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic        PSEL,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);

    // the first ACCESS cycle is spent in IDLE and counts as one wait cycle
    localparam logic [3:0] WAIT_LOAD =
        (WAIT_CYCLES > 1) ? 4'(WAIT_CYCLES - 2) : 4'd0;

    bus_state_e       state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic             pready_q, pready_d;
    logic [31:0]      prdata_q, prdata_d;

    logic             en_q, en_d;
    logic [CNT_W-1:0] psc_q, psc_d;
    logic [CNT_W-1:0] arr_q, arr_d;

    logic [2:0]       addr;
    logic             wr_en;
    logic             go_resp;
    logic             clr;
    logic             uif_clr;
    logic [31:0]      rdata;
    logic [CNT_W-1:0] tcnt;
    logic             uif;

    assign addr  = PADDR[4:2];
    assign wr_en = (state_q == ST_RESP) & PSEL & PENABLE & PWRITE;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pready_d = 1'b0;
        prdata_d = '0;
        go_resp  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (PSEL && PENABLE) begin
                    if (WAIT_CYCLES > 1) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        go_resp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 4'd0) begin
                    go_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (go_resp) begin
            state_d  = ST_RESP;
            pready_d = 1'b1;
            prdata_d = PWRITE ? 32'd0 : rdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q  <= ST_IDLE;
            wcnt_q   <= '0;
            pready_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
        end
    end

    assign PREADY = pready_q;
    assign PRDATA = prdata_q;

    always_comb begin
        en_d    = en_q;
        psc_d   = psc_q;
        arr_d   = arr_q;
        clr     = 1'b0;
        uif_clr = 1'b0;
        if (wr_en) begin
            case (addr)
                OFF_TCR: begin
                    en_d = PWDATA[TCR_EN];
                    clr  = PWDATA[TCR_CLR];
                end
                OFF_PSC: psc_d   = PWDATA[CNT_W-1:0];
                OFF_ARR: arr_d   = PWDATA[CNT_W-1:0];
                OFF_TSR: uif_clr = PWDATA[TSR_UIF];
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            en_q  <= 1'b0;
            psc_q <= '0;
            arr_q <= '0;
        end else begin
            en_q  <= en_d;
            psc_q <= psc_d;
            arr_q <= arr_d;
        end
    end

    timer_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (PCLK),
        .rst_n   (PRESET),
        .en      (en_q),
        .clr     (clr),
        .psc     (psc_q),
        .arr     (arr_q),
        .uif_clr (uif_clr),
        .tcnt    (tcnt),
        .uif     (uif)
    );

`ifdef APB_TIMER_IRQ_EN
    logic ier_q, ier_d;
    logic irq_q, irq_d;

    always_comb begin
        ier_d = ier_q;
        if (wr_en && (addr == OFF_IER)) begin
            ier_d = PWDATA[IER_UIE];
        end
        irq_d = uif & ier_q;
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            ier_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ier_q <= ier_d;
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic ier_q;
    logic unused_uif_top;
    assign ier_q          = 1'b0;
    assign unused_uif_top = uif;
    assign irq            = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            OFF_TCR:  rdata = {31'd0, en_q};
            OFF_TCNT: rdata = 32'(tcnt);
            OFF_PSC:  rdata = 32'(psc_q);
            OFF_ARR:  rdata = 32'(arr_q);
            OFF_TSR:  rdata = {31'd0, uif};
            OFF_IER:  rdata = {31'd0, ier_q};
            default:  rdata = '0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA};

endmodule

// File: tb/tb_apb_timer_slave.sv
// Self-checking bench for apb_timer_slave: directed and randomized APB traffic
// against an arithmetic model of the timer register map.
module tb_apb_timer_slave;

    localparam int WC = 2;

    logic        PCLK;
    logic        PRESET;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;
    int unsigned rd_edge;
    int unsigned wr_edge;

`ifdef APB_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    // model of the programmer-visible state
    int unsigned m_psc, m_arr, m_start, m_en_edge;
    bit          m_run, m_uif, m_ier;

    apb_timer_slave #(
        .CNT_W       (32),
        .WAIT_CYCLES (WC)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .irq     (irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // count value after t ticks starting from m_start
    function automatic int unsigned tc(int unsigned n);
        int unsigned t;
        t = n / (m_psc + 1);
        if (t == 0) return m_start;
        if (m_start > m_arr) return (t - 1) % (m_arr + 1);
        return (m_start + t) % (m_arr + 1);
    endfunction

    function automatic bit uf(int unsigned n);
        int unsigned t;
        t = n / (m_psc + 1);
        if (t == 0) return 1'b0;
        if (m_start > m_arr) return 1'b1;
        return (m_start + t) > m_arr;
    endfunction

    function automatic logic [31:0] exp_reg(logic [31:0] a, int unsigned e);
        int unsigned n;
        n = e - 1 - m_en_edge;
        case (a[4:2])
            3'd0: return {31'd0, m_run};
            3'd1: return m_run ? tc(n) : m_start;
            3'd2: return m_psc;
            3'd3: return m_arr;
            3'd4: return IRQ_ON ? {31'd0, m_uif | (m_run && uf(n))} : 32'd0;
            3'd5: return IRQ_ON ? {31'd0, m_ier} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic xfer(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata);
        int waits;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0;
        PADDR = a; PWRITE = wr; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 20) begin
            waits++;
            @(posedge PCLK); #1;
        end
        chk("wait_states", waits, WC);
        rdata = PRDATA;
        rd_edge = cyc;
        @(posedge PCLK); #1;
        wr_edge = cyc;
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("pready_one_cycle", {31'd0, PREADY}, 32'd0);
    endtask

    task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int unsigned n;
        xfer(1'b1, a, d, r);
        case (a[4:2])
            3'd0: begin
                if (m_run) begin
                    n = d[1] ? wr_edge - 1 - m_en_edge : wr_edge - m_en_edge;
                    m_uif   = m_uif | uf(n);
                    m_start = tc(n);
                end
                if (d[1]) m_start = 0;
                m_run     = d[0];
                m_en_edge = wr_edge;
            end
            3'd2: m_psc = d;
            3'd3: m_arr = d;
            3'd4: if (d[0] && !m_run) m_uif = 1'b0;
            3'd5: m_ier = d[0];
            default: ;
        endcase
    endtask

    task automatic apb_rd_chk(input string tag, input logic [31:0] a);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, r);
        chk(tag, r, exp_reg(a, rd_edge));
    endtask

    task automatic model_reset();
        m_psc = 0; m_arr = 0; m_start = 0; m_en_edge = 0;
        m_run = 0; m_uif = 0; m_ier = 0;
    endtask

    initial begin
        logic [31:0] r;
        int waits;
        model_reset();
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        #12;
        chk("rst_pready", {31'd0, PREADY}, 32'd0);
        chk("rst_prdata", PRDATA, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        #10 PRESET = 1'b1;

        for (int a = 0; a < 8; a++) apb_rd_chk("rst_reg", 32'(a * 4));

        apb_wr(32'h0C, 32'h5);
        apb_rd_chk("arr_rb", 32'h0C);
        apb_wr(32'h04, 32'h55);
        apb_rd_chk("tcnt_ro", 32'h04);
        apb_wr(32'h1C, 32'hFFFF_FFFF);
        apb_rd_chk("unmapped", 32'h1C);

        // abort: drop PSEL while waiting
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h0C;
        PWRITE = 1'b1; PWDATA = 32'h77;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        chk("abort_wait_low", {31'd0, PREADY}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge PCLK); #1;
            chk("abort_no_ready", {31'd0, PREADY}, 32'd0);
        end
        apb_rd_chk("abort_no_write", 32'h0C);

        // directed count PSC=3 ARR=4, then CLR while running
        apb_wr(32'h08, 32'd3);
        apb_wr(32'h0C, 32'd4);
        apb_wr(32'h00, 32'h1);
        for (int i = 0; i < 5; i++) begin
            repeat (i) @(posedge PCLK);
            apb_rd_chk("count_tcnt", 32'h04);
        end
        apb_rd_chk("count_uif", 32'h10);
        apb_wr(32'h00, 32'h3);
        apb_rd_chk("clr_tcr", 32'h00);
        apb_rd_chk("clr_tcnt", 32'h04);
        apb_rd_chk("clr_resume", 32'h04);
        apb_wr(32'h00, 32'h0);
        apb_rd_chk("hold_a", 32'h04);
        repeat (7) @(posedge PCLK);
        apb_rd_chk("hold_b", 32'h04);

        // ARR lowered below the held count
        apb_wr(32'h08, 32'd0);
        apb_wr(32'h00, 32'h2);
        apb_wr(32'h10, 32'h1);
        apb_wr(32'h0C, 32'd30);
        apb_wr(32'h00, 32'h1);
        repeat (6) @(posedge PCLK);
        apb_wr(32'h00, 32'h0);
        apb_rd_chk("low_arr_hold", 32'h04);
        apb_wr(32'h10, 32'h1);
        apb_wr(32'h0C, 32'd2);
        apb_wr(32'h00, 32'h1);
        apb_rd_chk("low_arr_wrap", 32'h04);
        apb_rd_chk("low_arr_uif", 32'h10);
        apb_wr(32'h00, 32'h0);

        // randomized rounds
        for (int k = 0; k < 6; k++) begin
            apb_wr(32'h00, 32'h2);
            apb_wr(32'h10, 32'h1);
            apb_wr(32'h08, $urandom_range(0, 3));
            apb_wr(32'h0C, $urandom_range(0, 6));
            apb_wr(32'h00, 32'h1);
            for (int j = 0; j < 3; j++) begin
                repeat ($urandom_range(0, 9)) @(posedge PCLK);
                apb_rd_chk("rand_tcnt", 32'h04);
            end
            apb_rd_chk("rand_uif", 32'h10);
            apb_wr(32'h00, 32'h0);
            apb_rd_chk("rand_hold", 32'h04);
        end

        // update interrupt
        apb_wr(32'h00, 32'h2);
        apb_wr(32'h10, 32'h1);
        apb_wr(32'h08, 32'd0);
        apb_wr(32'h0C, 32'd0);
        apb_wr(32'h14, 32'h1);
        apb_rd_chk("ier_rb", 32'h14);
        apb_wr(32'h00, 32'h1);
        @(posedge PCLK); #1;
        chk("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge PCLK); #1;
        chk("irq_set", {31'd0, irq}, {31'd0, IRQ_ON});
        apb_wr(32'h10, 32'h1);
        apb_rd_chk("uif_set_wins", 32'h10);
        chk("irq_held", {31'd0, irq}, {31'd0, IRQ_ON});

        // async reset in the middle of a response
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h00; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (PREADY !== 1'b1 && waits < 20) begin
            waits++;
            @(posedge PCLK); #1;
        end
        chk("mid_resp_data", PRDATA, 32'h1);
        #2 PRESET = 1'b0;
        #1;
        chk("arst_pready", {31'd0, PREADY}, 32'd0);
        chk("arst_prdata", PRDATA, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        model_reset();
        #13 PRESET = 1'b1;
        for (int a = 0; a < 6; a++) apb_rd_chk("post_rst_reg", 32'(a * 4));
        chk("post_rst_irq", {31'd0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
